// File: rtl/spi_frame_fifo.sv
// SPI frame FIFO: edge-detected word capture, paced one-word-per-pulse drain to the middleware.
// Optional feature: define FIFO_OVERFLOW_CNT_EN to add the saturating 8-bit OVF_COUNT output.
module spi_frame_fifo #(
  parameter int BITWIDTH   = 24,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      CLK_SYS,
  input  logic                      RSTN,
  input  logic [BITWIDTH-1:0]       DIN,
  input  logic                      DIN_RDY,
  output logic [BITWIDTH-1:0]       DOUT,
  output logic                      DOUT_RDY,
  output logic [$clog2(DEPTH):0]    LEVEL,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      OVERFLOW
`ifdef FIFO_OVERFLOW_CNT_EN
  ,
  output logic [7:0]                OVF_COUNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  logic [BITWIDTH-1:0] mem [DEPTH];

  logic                din_rdy_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic [1:0]          state_q, state_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [BITWIDTH-1:0] dout_q, dout_d;

  logic wr_event, pop, wr_accept, wr_drop;

  always_comb begin
    wr_event  = DIN_RDY & ~din_rdy_q;
    pop       = (state_q == ST_PRESENT);
    // A full FIFO can still take a word when the PRESENT pop frees the slot that same cycle.
    wr_accept = wr_event & (~full_q | pop);
    wr_drop   = wr_event & full_q & ~pop;

    level_d = level_q;
    if (wr_accept && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!wr_accept && pop) begin
      level_d = level_q - LW'(1);
    end
    empty_d  = (level_d == '0);
    full_d   = (level_d == LW'(DEPTH));
    wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q | wr_drop;
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = dout_q;
    case (state_q)
      ST_IDLE: begin
        // Load the output word on the way into PRESENT so the slot may be rewritten during the pop.
        if (!empty_q) begin
          state_d = ST_PRESENT;
          dout_d  = mem[rd_ptr_q];
        end
      end
      ST_PRESENT: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      din_rdy_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      dout_q    <= '0;
    end else begin
      din_rdy_q <= DIN_RDY;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= DIN;
    end
  end

`ifdef FIFO_OVERFLOW_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_drop && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign OVF_COUNT = ovf_cnt_q;
`endif

  assign DOUT     = dout_q;
  assign DOUT_RDY = (state_q == ST_PRESENT);
  assign LEVEL    = level_q;
  assign EMPTY    = empty_q;
  assign FULL     = full_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_spi_frame_fifo.sv
// Directed bench for spi_frame_fifo: a default instance (GAP_CYCLES=4) and a slow-drain
// instance (GAP_CYCLES=24) used where the FIFO must fill without an intervening pop.
module tb_spi_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance
  logic        rstn_f = 1'b0;
  logic [23:0] din_f = '0;
  logic        din_rdy_f = 1'b0;
  logic [23:0] dout_f;
  logic        dout_rdy_f;
  logic [3:0]  level_f;
  logic        empty_f, full_f, ovf_f;

  // slow-drain instance
  logic        rstn_s = 1'b0;
  logic [23:0] din_s = '0;
  logic        din_rdy_s = 1'b0;
  logic [23:0] dout_s;
  logic        dout_rdy_s;
  logic [3:0]  level_s;
  logic        empty_s, full_s, ovf_s;

`ifdef FIFO_OVERFLOW_CNT_EN
  logic [7:0]  ovf_cnt_f, ovf_cnt_s;
`endif

  spi_frame_fifo u_dut (
    .CLK_SYS  (clk),
    .RSTN     (rstn_f),
    .DIN      (din_f),
    .DIN_RDY  (din_rdy_f),
    .DOUT     (dout_f),
    .DOUT_RDY (dout_rdy_f),
    .LEVEL    (level_f),
    .EMPTY    (empty_f),
    .FULL     (full_f),
    .OVERFLOW (ovf_f)
`ifdef FIFO_OVERFLOW_CNT_EN
    ,
    .OVF_COUNT(ovf_cnt_f)
`endif
  );

  spi_frame_fifo #(.GAP_CYCLES(24)) u_slow (
    .CLK_SYS  (clk),
    .RSTN     (rstn_s),
    .DIN      (din_s),
    .DIN_RDY  (din_rdy_s),
    .DOUT     (dout_s),
    .DOUT_RDY (dout_rdy_s),
    .LEVEL    (level_s),
    .EMPTY    (empty_s),
    .FULL     (full_s),
    .OVERFLOW (ovf_s)
`ifdef FIFO_OVERFLOW_CNT_EN
    ,
    .OVF_COUNT(ovf_cnt_s)
`endif
  );

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_slow();
    rstn_s    = 1'b0;
    din_rdy_s = 1'b0;
    tick();
    tick();
    rstn_s = 1'b1;
  endtask

  // Writes one word into the slow instance and returns positioned in its PRESENT cycle.
  task automatic prime_slow(output bit found);
    found     = 1'b0;
    din_s     = 24'hFFFFFF;
    din_rdy_s = 1'b1;
    tick();
    din_rdy_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_rdy_s) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (dout_f !== 24'h0)  begin errors++; $display("FAIL reset_dout got=%h exp=000000", dout_f); end
    checks++; if (dout_rdy_f !== 1'b0) begin errors++; $display("FAIL reset_dout_rdy got=%b exp=0", dout_rdy_f); end
    checks++; if (level_f !== 4'd0)  begin errors++; $display("FAIL reset_level got=%0d exp=0", level_f); end
    checks++; if (empty_f !== 1'b1)  begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_f); end
    checks++; if (full_f !== 1'b0)   begin errors++; $display("FAIL reset_full got=%b exp=0", full_f); end
    checks++; if (ovf_f !== 1'b0)    begin errors++; $display("FAIL reset_overflow got=%b exp=0", ovf_f); end
`ifdef FIFO_OVERFLOW_CNT_EN
    checks++; if (ovf_cnt_f !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got=%0d exp=0", ovf_cnt_f); end
`endif
    rstn_f = 1'b1;
    rstn_s = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_single();
    din_f     = 24'hA5B6C7;
    din_rdy_f = 1'b1;
    tick();
    din_rdy_f = 1'b0;
    checks++; if (dout_rdy_f !== 1'b0) begin errors++; $display("FAIL single_early_rdy got=%b exp=0", dout_rdy_f); end
    checks++; if (level_f !== 4'd1)    begin errors++; $display("FAIL single_level got=%0d exp=1", level_f); end
    checks++; if (empty_f !== 1'b0)    begin errors++; $display("FAIL single_empty got=%b exp=0", empty_f); end
    tick();
    checks++; if (dout_rdy_f !== 1'b1)     begin errors++; $display("FAIL single_rdy got=%b exp=1", dout_rdy_f); end
    checks++; if (dout_f !== 24'hA5B6C7)   begin errors++; $display("FAIL single_dout got=%h exp=a5b6c7", dout_f); end
    tick();
    checks++; if (dout_rdy_f !== 1'b0)     begin errors++; $display("FAIL single_rdy_width got=%b exp=0", dout_rdy_f); end
    checks++; if (dout_f !== 24'hA5B6C7)   begin errors++; $display("FAIL single_dout_hold got=%h exp=a5b6c7", dout_f); end
    checks++; if (empty_f !== 1'b1)        begin errors++; $display("FAIL single_empty_after got=%b exp=1", empty_f); end
    $display("single word delivered dout=%h", dout_f);
    repeat (6) tick();
  endtask

  task automatic test_burst();
    int          pt [3];
    logic [23:0] pv [3];
    int          np = 0;
    int          max_level = 0;
    logic [23:0] held = '0;
    for (int c = 0; c < 20; c++) begin
      din_rdy_f = (c == 0 || c == 2 || c == 4);
      din_f     = 24'(c / 2 + 1);
      if (dout_rdy_f) begin
        if (np < 3) begin pt[np] = c; pv[np] = dout_f; end
        np++;
      end
      if (int'(level_f) > max_level) max_level = int'(level_f);
      if (c == 11) held = dout_f;
      tick();
    end
    din_rdy_f = 1'b0;
    checks++; if (np !== 3) begin errors++; $display("FAIL burst_pulse_count got=%0d exp=3", np); end
    if (np >= 3) begin
      // Pulses at cycles 2, 8, 14: four GAP cycles plus one IDLE cycle between them.
      for (int i = 0; i < 3; i++) begin
        $display("burst word %0d at cycle %0d dout=%h", i, pt[i], pv[i]);
        checks++; if (pv[i] !== 24'(i + 1)) begin errors++; $display("FAIL burst_value%0d got=%h exp=%h", i, pv[i], 24'(i + 1)); end
        checks++; if (pt[i] !== 2 + 6 * i)  begin errors++; $display("FAIL burst_time%0d got=%0d exp=%0d", i, pt[i], 2 + 6 * i); end
      end
    end
    checks++; if (max_level !== 2)   begin errors++; $display("FAIL burst_peak_level got=%0d exp=2", max_level); end
    checks++; if (held !== 24'h2)    begin errors++; $display("FAIL burst_dout_hold got=%h exp=000002", held); end
    checks++; if (empty_f !== 1'b1)  begin errors++; $display("FAIL burst_empty_end got=%b exp=1", empty_f); end
    repeat (4) tick();
  endtask

  task automatic test_held_high();
    int          np = 0;
    int          first_c = -1;
    logic [23:0] first_v = '0;
    for (int c = 0; c < 30; c++) begin
      din_rdy_f = (c < 20);
      din_f     = (c == 0) ? 24'h000777 : 24'h000888;
      if (dout_rdy_f) begin
        if (np == 0) begin first_c = c; first_v = dout_f; end
        np++;
      end
      tick();
    end
    din_rdy_f = 1'b0;
    $display("held-high run: pulses=%0d first dout=%h", np, first_v);
    checks++; if (np !== 1)              begin errors++; $display("FAIL held_pulse_count got=%0d exp=1", np); end
    checks++; if (first_v !== 24'h000777) begin errors++; $display("FAIL held_value got=%h exp=000777", first_v); end
    checks++; if (first_c !== 2)         begin errors++; $display("FAIL held_latency got=%0d exp=2", first_c); end
    checks++; if (level_f !== 4'd0)      begin errors++; $display("FAIL held_level got=%0d exp=0", level_f); end
  endtask

  task automatic test_release_edge();
    int          np = 0;
    logic [23:0] v = '0;
    rstn_f    = 1'b0;
    din_f     = 24'h000031;
    din_rdy_f = 1'b1;
    tick();
    tick();
    rstn_f = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (dout_rdy_f) begin np++; v = dout_f; end
      tick();
    end
    din_rdy_f = 1'b0;
    $display("release with DIN_RDY high: pulses=%0d dout=%h", np, v);
    checks++; if (np !== 1)         begin errors++; $display("FAIL release_edge_count got=%0d exp=1", np); end
    checks++; if (v !== 24'h000031) begin errors++; $display("FAIL release_edge_value got=%h exp=000031", v); end
  endtask

  task automatic test_overflow();
    bit found;
    reset_slow();
    prime_slow(found);
    checks++; if (!found) begin errors++; $display("FAIL ovf_prime_timeout got=none exp=pulse"); end
    tick();
    for (int i = 0; i < 10; i++) begin
      din_s     = 24'h000100 + 24'(i);
      din_rdy_s = 1'b1;
      tick();
      din_rdy_s = 1'b0;
      tick();
    end
    checks++; if (full_s !== 1'b1)  begin errors++; $display("FAIL ovf_full got=%b exp=1", full_s); end
    checks++; if (level_s !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d exp=8", level_s); end
    checks++; if (ovf_s !== 1'b1)   begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf_s); end
`ifdef FIFO_OVERFLOW_CNT_EN
    checks++; if (ovf_cnt_s !== 8'd2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", ovf_cnt_s); end
`endif
    for (int w = 0; w < 8; w++) begin
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (dout_rdy_s) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL ovf_drain%0d got=timeout exp=%h", w, 24'h000100 + 24'(w));
      end else if (dout_s !== 24'h000100 + 24'(w)) begin
        errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", w, dout_s, 24'h000100 + 24'(w));
      end else begin
        $display("overflow drain word %0d dout=%h", w, dout_s);
      end
    end
    tick();
    checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL ovf_empty_end got=%b exp=1", empty_s); end
    checks++; if (ovf_s !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_s); end
  endtask

  task automatic test_simultaneous();
    bit found;
    reset_slow();
    prime_slow(found);
    checks++; if (!found) begin errors++; $display("FAIL sim_prime_timeout got=none exp=pulse"); end
    tick();
    for (int i = 0; i < 8; i++) begin
      din_s     = 24'h000200 + 24'(i);
      din_rdy_s = 1'b1;
      tick();
      din_rdy_s = 1'b0;
      tick();
    end
    checks++; if (level_s !== 4'd8) begin errors++; $display("FAIL sim_fill_level got=%0d exp=8", level_s); end
    checks++; if (full_s !== 1'b1)  begin errors++; $display("FAIL sim_fill_full got=%b exp=1", full_s); end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dout_rdy_s) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL sim_present_timeout got=none exp=pulse"); end
    checks++; if (dout_s !== 24'h000200) begin errors++; $display("FAIL sim_present_dout got=%h exp=000200", dout_s); end
    // Write edge lands in the PRESENT cycle itself.
    din_s     = 24'hABCDEF;
    din_rdy_s = 1'b1;
    tick();
    din_rdy_s = 1'b0;
    $display("simultaneous write/pop: level=%0d overflow=%b", level_s, ovf_s);
    checks++; if (level_s !== 4'd8) begin errors++; $display("FAIL sim_level got=%0d exp=8", level_s); end
    checks++; if (full_s !== 1'b1)  begin errors++; $display("FAIL sim_full got=%b exp=1", full_s); end
    checks++; if (ovf_s !== 1'b0)   begin errors++; $display("FAIL sim_overflow got=%b exp=0", ovf_s); end
`ifdef FIFO_OVERFLOW_CNT_EN
    checks++; if (ovf_cnt_s !== 8'd0) begin errors++; $display("FAIL sim_ovf_count got=%0d exp=0", ovf_cnt_s); end
`endif
  endtask

  task automatic test_reset_abort();
    bit found;
    int np = 0;
    reset_slow();
    prime_slow(found);
    checks++; if (!found) begin errors++; $display("FAIL abort_prime_timeout got=none exp=pulse"); end
    tick();
    for (int i = 0; i < 3; i++) begin
      din_s     = 24'h000300 + 24'(i);
      din_rdy_s = 1'b1;
      tick();
      din_rdy_s = 1'b0;
      tick();
    end
    checks++; if (level_s !== 4'd3) begin errors++; $display("FAIL abort_pre_level got=%0d exp=3", level_s); end
    tick();
    rstn_s = 1'b0;
    #1;
    checks++; if (dout_s !== 24'h0)    begin errors++; $display("FAIL abort_dout got=%h exp=000000", dout_s); end
    checks++; if (dout_rdy_s !== 1'b0) begin errors++; $display("FAIL abort_dout_rdy got=%b exp=0", dout_rdy_s); end
    checks++; if (level_s !== 4'd0)    begin errors++; $display("FAIL abort_level got=%0d exp=0", level_s); end
    checks++; if (empty_s !== 1'b1)    begin errors++; $display("FAIL abort_empty got=%b exp=1", empty_s); end
    checks++; if (full_s !== 1'b0)     begin errors++; $display("FAIL abort_full got=%b exp=0", full_s); end
    checks++; if (ovf_s !== 1'b0)      begin errors++; $display("FAIL abort_overflow got=%b exp=0", ovf_s); end
    tick();
    tick();
    rstn_s = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (dout_rdy_s) np++;
      tick();
    end
    $display("post-abort run: pulses=%0d", np);
    checks++; if (np !== 0)         begin errors++; $display("FAIL abort_no_pulse got=%0d exp=0", np); end
    checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL abort_empty_after got=%b exp=1", empty_s); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_held_high();
    test_release_edge();
    test_overflow();
    test_simultaneous();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
